dualport_sram_clr: RTL

DUALPORT_SRAM_CLR -- requirements
Module: dualport_sram_clr

---
 rtl/dualport_sram_pkg.sv | 21 ++
 rtl/sram_be_merge.sv | 19 +
 rtl/dualport_sram_clr.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dualport_sram_pkg.sv
// Shared definitions for the clearable dual-port SRAM: FSM encoding,
// byte-lane helpers and parameter legality checks.
package dualport_sram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    CLEAR_INIT = 2'd0,
    IDLE       = 2'd1,
    CLEAR      = 2'd2
  } state_e;

  function automatic int lane_count(input int data_width);
    return data_width / BYTE_W;
  endfunction

  function automatic bit rd_lat_legal(input int rd_lat);
    return (rd_lat == 1) || (rd_lat == 2);
  endfunction

endpackage

// File: rtl/sram_be_merge.sv
// Byte-lane merge: lanes with their enable set take the new data, the rest keep the old word.
module sram_be_merge
  import dualport_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NB         = lane_count(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] old_i,
  input  logic [DATA_WIDTH-1:0] new_i,
  input  logic [NB-1:0]         be_i,
  output logic [DATA_WIDTH-1:0] merged_o
);

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign merged_o[gi*BYTE_W +: BYTE_W] = be_i[gi] ? new_i[gi*BYTE_W +: BYTE_W]
                                                    : old_i[gi*BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/dualport_sram_clr.sv
// One-write/one-read SRAM with byte enables, 1- or 2-cycle read latency,
// optional write-to-read bypass, and a one-word-per-cycle clear sweep.
module dualport_sram_clr
  import dualport_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int RAM_DEPTH  = 16,
  parameter int RD_LAT     = 1,
  parameter int WR_BYPASS  = 1
) (
  input  logic                             clk,
  input  logic                             rsr,
  input  logic                             i_cs,
  input  logic                             i_clr,
  input  logic                             i_wr_en,
  input  logic [ADDR_WIDTH-1:0]            i_address_w,
  input  logic [DATA_WIDTH-1:0]            i_write_data,
  input  logic [lane_count(DATA_WIDTH)-1:0] i_wr_be,
  input  logic                             i_rd_en,
  input  logic [ADDR_WIDTH-1:0]            i_address_r,
  output logic [DATA_WIDTH-1:0]            o_read_data,
  output logic                             o_rd_valid,
  output logic                             o_busy,
  output logic                             o_err
);

  localparam int                    NB        = lane_count(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("dualport_sram_clr: RD_LAT must be 1 or 2");
  end
  if ((DATA_WIDTH % BYTE_W) != 0 || RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_geometry
    $error("dualport_sram_clr: DATA_WIDTH must be a byte multiple and RAM_DEPTH <= 2**ADDR_WIDTH");
  end

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;
  logic                   clr_we;
  logic                   busy;
  logic                   wr_in_range, rd_in_range;
  logic                   wr_ok, rd_ok;
  logic                   err_d, err_q;

  logic [DATA_WIDTH-1:0]  mem_q [RAM_DEPTH];
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic [DATA_WIDTH-1:0]  old_word, merged_word, rd_word;

  logic                   rd_vld1_q;
  logic [DATA_WIDTH-1:0]  rd_data1_q;

  assign busy        = (state_q != IDLE);
  assign wr_in_range = ({1'b0, i_address_w} < DEPTH_W);
  assign rd_in_range = ({1'b0, i_address_r} < DEPTH_W);
  assign wr_ok       = i_cs & i_wr_en & wr_in_range & ~busy;
  assign rd_ok       = i_cs & i_rd_en & rd_in_range & ~busy;
  assign err_d       = i_cs & ~busy & ((i_wr_en & ~wr_in_range) | (i_rd_en & ~rd_in_range));

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      CLEAR_INIT, CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end
      IDLE: begin
        if (i_clr) state_d = CLEAR;
      end
      default: state_d = CLEAR_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rsr) begin
    if (rsr) begin
      state_q   <= CLEAR_INIT;
      clr_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      err_q     <= err_d;
    end
  end

  // One merge instance serves both the write path and the bypass path:
  // on a same-address collision the merged write word is exactly the bypass value.
  assign old_word = mem_q[i_address_w];

  sram_be_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .NB         (NB)
  ) u_be_merge (
    .old_i    (old_word),
    .new_i    (i_write_data),
    .be_i     (i_wr_be),
    .merged_o (merged_word)
  );

  always_comb begin
    mem_we    = wr_ok;
    mem_addr  = i_address_w;
    mem_wdata = merged_word;
    if (clr_we) begin
      mem_we    = ~rsr;
      mem_addr  = clr_cnt_q;
      mem_wdata = '0;
    end
  end

  // The array has no reset; only the clear sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  if (WR_BYPASS != 0) begin : g_bypass
    assign rd_word = (wr_ok && (i_address_w == i_address_r)) ? merged_word : mem_q[i_address_r];
  end else begin : g_no_bypass
    assign rd_word = mem_q[i_address_r];
  end

  always_ff @(posedge clk or posedge rsr) begin
    if (rsr) begin
      rd_vld1_q  <= 1'b0;
      rd_data1_q <= '0;
    end else begin
      rd_vld1_q <= rd_ok;
      if (rd_ok) rd_data1_q <= rd_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic                  rd_vld2_q;
    logic [DATA_WIDTH-1:0] rd_data2_q;

    always_ff @(posedge clk or posedge rsr) begin
      if (rsr) begin
        rd_vld2_q  <= 1'b0;
        rd_data2_q <= '0;
      end else begin
        rd_vld2_q <= rd_vld1_q;
        if (rd_vld1_q) rd_data2_q <= rd_data1_q;
      end
    end

    assign o_read_data = rd_data2_q;
    assign o_rd_valid  = rd_vld2_q;
  end else begin : g_lat1
    assign o_read_data = rd_data1_q;
    assign o_rd_valid  = rd_vld1_q;
  end

  assign o_busy = busy;
  assign o_err  = err_q;

endmodule
